// File: rtl/icache_direct_mapped_pkg.sv
// Shared definitions for the direct-mapped instruction cache: memory bus
// bit layout, block word positions, memory stall count and FSM encodings.
package icache_direct_mapped_pkg;

  localparam int MEM_REQ_SIZE    = 17;
  localparam int MEM_REQ_VALID   = 16;
  localparam int MEM_REQ_ADDR_W  = 16;
  localparam int MEM_DATA_SIZE   = 65;
  localparam int MEM_DATA_READY  = 64;
  localparam int BLOCK_BITS      = 64;

  // Word k of a block sits at bit offset BLOCK_WORD_(k+1)
  localparam int BLOCK_WORD_1    = 0;
  localparam int BLOCK_WORD_2    = 16;
  localparam int BLOCK_WORD_3    = 32;
  localparam int BLOCK_WORD_4    = 48;

  localparam int MEM_STALL_COUNT = 2;

  typedef enum logic [1:0] {
    ICACHE_IDLE       = 2'b00,
    ICACHE_FILL_ISSUE = 2'b01,
    ICACHE_FILL_WAIT  = 2'b10
  } icache_state_e;

  function automatic logic [15:0] block_word(input logic [BLOCK_BITS-1:0] blk,
                                             input logic [1:0] off);
    logic [15:0] w;
    case (off)
      2'd0:    w = blk[BLOCK_WORD_1 +: 16];
      2'd1:    w = blk[BLOCK_WORD_2 +: 16];
      2'd2:    w = blk[BLOCK_WORD_3 +: 16];
      default: w = blk[BLOCK_WORD_4 +: 16];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = the cache, master = fetch stage plus main memory.
interface icache_direct_mapped_if;
  import icache_direct_mapped_pkg::*;

  logic                     i_readM;
  logic [15:0]              i_address;
  logic                     i_flush;
  logic [15:0]              i_data;
  logic                     i_ready;
  logic [MEM_REQ_SIZE-1:0]  mem_req;
  logic [MEM_DATA_SIZE-1:0] mem_data;

  modport slave (
    input  i_readM, i_address, i_flush, mem_data,
    output i_data, i_ready, mem_req
  );

  modport master (
    output i_readM, i_address, i_flush, mem_data,
    input  i_data, i_ready, mem_req
  );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read by
// index, one write port, and a flush that clears every valid bit.
module icache_line_array #(
  parameter int LINES   = 4,
  parameter int IDX_W   = 2,
  parameter int TAG_W   = 12,
  parameter int BLOCK_W = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               wr_en,
  input  logic               wr_set_valid,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_block,
  input  logic               flush
);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags   [LINES];
  logic [BLOCK_W-1:0] blocks [LINES];

  // Flush has priority so a fill landing in the flush cycle stays invalid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]   <= wr_tag;
      blocks[wr_index] <= wr_block;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_block = blocks[rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with zero-cycle hits and 4-word
// block refill. Optional hit/miss counters are built with ICACHE_STATS_EN.
//
// state             | meaning
// ICACHE_IDLE       | serve hits; a miss latches the block address
// ICACHE_FILL_ISSUE | one cycle of request; stale MEM_DATA_READY ignored
// ICACHE_FILL_WAIT  | request held until MEM_DATA_READY, then install line
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int LINES     = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  icache_direct_mapped_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - 2 - IDX_W;

  icache_state_e         state;
  icache_state_e         state_nxt;
  logic [WORD_SIZE-1:0]  blk_addr;
  logic                  fill_killed;
  logic [IDX_W-1:0]      rd_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_BITS-1:0] rd_block;
  logic                  hit;
  logic                  miss;
  logic                  fill_done;

  assign rd_index  = bus.i_address[2 +: IDX_W];
  assign req_tag   = bus.i_address[WORD_SIZE-1 -: TAG_W];
  assign hit       = bus.i_readM && rd_valid && (rd_tag == req_tag);
  assign miss      = bus.i_readM && !hit;
  assign fill_done = (state == ICACHE_FILL_WAIT) && bus.mem_data[MEM_DATA_READY];

  icache_line_array #(
    .LINES   (LINES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .BLOCK_W (BLOCK_BITS)
  ) u_lines (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_block     (rd_block),
    .wr_en        (fill_done),
    .wr_set_valid (!fill_killed && !bus.i_flush),
    .wr_index     (blk_addr[2 +: IDX_W]),
    .wr_tag       (blk_addr[WORD_SIZE-1 -: TAG_W]),
    .wr_block     (bus.mem_data[BLOCK_BITS-1:0]),
    .flush        (bus.i_flush)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ICACHE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A flush seen during a fill poisons that fill so its line is never validated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_addr    <= '0;
      fill_killed <= 1'b0;
    end else if (state == ICACHE_IDLE) begin
      fill_killed <= 1'b0;
      if (miss) begin
        blk_addr <= {bus.i_address[WORD_SIZE-1:2], 2'b00};
      end
    end else if (bus.i_flush) begin
      fill_killed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ICACHE_IDLE:       if (miss) state_nxt = ICACHE_FILL_ISSUE;
      ICACHE_FILL_ISSUE: state_nxt = ICACHE_FILL_WAIT;
      ICACHE_FILL_WAIT:  if (bus.mem_data[MEM_DATA_READY]) state_nxt = ICACHE_IDLE;
      default:           state_nxt = ICACHE_IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    bus.mem_req = '0;
    case (state)
      ICACHE_IDLE: begin
        if (hit && !bus.i_flush) begin
          bus.i_ready = 1'b1;
          bus.i_data  = block_word(rd_block, bus.i_address[1:0]);
        end
      end
      ICACHE_FILL_ISSUE,
      ICACHE_FILL_WAIT: begin
        bus.mem_req = {1'b1, blk_addr};
      end
      default: begin
        bus.mem_req = '0;
      end
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.i_ready) begin
        hit_count <= hit_count + 16'd1;
      end
      if ((state == ICACHE_IDLE) && (state_nxt == ICACHE_FILL_ISSUE)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
